// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Single-outstanding AXI4-Lite initiator. A caller presents one command on a
// valid/ready strobe interface; the block turns it into an AXI-Lite write
// (AW + W + B) or read (AR + R) and then reports the outcome with a
// one-cycle rsp_valid pulse. A programmable timeout bounds how long the
// block waits for B or R, so a hung slave cannot stall the caller forever.
//
// Ports
//   clk, rst            : clock and asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready only while idle)
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr            : byte address
//   cmd_wdata/cmd_wstrb : write data and byte strobes
//   rsp_valid           : one-cycle pulse, transaction finished
//   rsp_write           : finished transaction was a write
//   rsp_rdata           : read data (0 for writes and on timeout)
//   rsp_resp            : BRESP/RRESP, or 2'b10 on timeout
//   rsp_timeout         : transaction ended by the timeout
//   M_AXI_*             : AXI4-Lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int                CNT_W      = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                            r_state;
    logic                              r_cmdReady;
    logic                              r_rspValid;
    logic                              r_rspWrite;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_rspRdata;
    logic [1:0]                        r_rspResp;
    logic                              r_rspTimeout;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awAddr;
    logic                              r_awValid;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_wData;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wStrb;
    logic                              r_wValid;
    logic                              r_bReady;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_arAddr;
    logic                              r_arValid;
    logic                              r_rReady;
    logic                              r_awDone;
    logic                              r_wDone;
    logic [CNT_W-1:0]                  r_timer;

    logic w_awHs;
    logic w_wHs;
    logic w_bHs;
    logic w_arHs;
    logic w_rHs;
    logic w_awDone;
    logic w_wDone;
    logic w_timerLast;

    // Handshake detection; the done flags fold in a handshake happening
    // this cycle so AW and W may complete in either order or together.
    assign w_awHs      = r_awValid & M_AXI_AWREADY;
    assign w_wHs       = r_wValid  & M_AXI_WREADY;
    assign w_bHs       = r_bReady  & M_AXI_BVALID;
    assign w_arHs      = r_arValid & M_AXI_ARREADY;
    assign w_rHs       = r_rReady  & M_AXI_RVALID;
    assign w_awDone    = r_awDone | w_awHs;
    assign w_wDone     = r_wDone  | w_wHs;
    assign w_timerLast = (r_timer == TIMER_LAST);

    // Transaction sequencer. Every output is a register written here, so
    // bus valids/readies and the response fields change only on clock
    // edges (or asynchronously to 0 on reset). rsp_valid defaults low and
    // is raised only on the edge that enters DONE, which makes it a single
    // cycle pulse. In the response states a handshake is tested before the
    // timeout so a response arriving in the final cycle still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cmdReady   <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspWrite   <= 1'b0;
            r_rspRdata   <= '0;
            r_rspResp    <= 2'b00;
            r_rspTimeout <= 1'b0;
            r_awAddr     <= '0;
            r_awValid    <= 1'b0;
            r_wData      <= '0;
            r_wStrb      <= '0;
            r_wValid     <= 1'b0;
            r_bReady     <= 1'b0;
            r_arAddr     <= '0;
            r_arValid    <= 1'b0;
            r_rReady     <= 1'b0;
            r_awDone     <= 1'b0;
            r_wDone      <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmdReady) begin
                        r_cmdReady <= 1'b0;
                        if (cmd_write) begin
                            r_awAddr  <= cmd_addr;
                            r_wData   <= cmd_wdata;
                            r_wStrb   <= cmd_wstrb;
                            r_awValid <= 1'b1;
                            r_wValid  <= 1'b1;
                            r_awDone  <= 1'b0;
                            r_wDone   <= 1'b0;
                            r_state   <= WR_REQ;
                        end else begin
                            r_arAddr  <= cmd_addr;
                            r_arValid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end else begin
                        // Also raises cmd_ready the first cycle after reset.
                        r_cmdReady <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (w_awHs) r_awValid <= 1'b0;
                    if (w_wHs)  r_wValid  <= 1'b0;
                    r_awDone <= w_awDone;
                    r_wDone  <= w_wDone;
                    if (w_awDone && w_wDone) begin
                        r_bReady <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_bHs) begin
                        r_bReady     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspWrite   <= 1'b1;
                        r_rspRdata   <= '0;
                        r_rspResp    <= M_AXI_BRESP;
                        r_rspTimeout <= 1'b0;
                        r_state      <= DONE;
                    end else if (w_timerLast) begin
                        r_bReady     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspWrite   <= 1'b1;
                        r_rspRdata   <= '0;
                        r_rspResp    <= RESP_SLVERR;
                        r_rspTimeout <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                RD_REQ: begin
                    if (w_arHs) begin
                        r_arValid <= 1'b0;
                        r_rReady  <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (w_rHs) begin
                        r_rReady     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspWrite   <= 1'b0;
                        r_rspRdata   <= M_AXI_RDATA;
                        r_rspResp    <= M_AXI_RRESP;
                        r_rspTimeout <= 1'b0;
                        r_state      <= DONE;
                    end else if (w_timerLast) begin
                        r_rReady     <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspWrite   <= 1'b0;
                        r_rspRdata   <= '0;
                        r_rspResp    <= RESP_SLVERR;
                        r_rspTimeout <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_cmdReady <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmdReady;
    assign rsp_valid     = r_rspValid;
    assign rsp_write     = r_rspWrite;
    assign rsp_rdata     = r_rspRdata;
    assign rsp_resp      = r_rspResp;
    assign rsp_timeout   = r_rspTimeout;
    assign M_AXI_AWADDR  = r_awAddr;
    assign M_AXI_AWVALID = r_awValid;
    assign M_AXI_WDATA   = r_wData;
    assign M_AXI_WSTRB   = r_wStrb;
    assign M_AXI_WVALID  = r_wValid;
    assign M_AXI_BREADY  = r_bReady;
    assign M_AXI_ARADDR  = r_arAddr;
    assign M_AXI_ARVALID = r_arValid;
    assign M_AXI_RREADY  = r_rReady;

endmodule
